hex_scan_driver: RTL



---
 rtl/hex_scan_driver.sv | 101 ++++++++++
 1 files changed

// File: rtl/hex_scan_driver.sv
// Time-multiplexed scan driver for common-anode seven-segment digits.
// Double-buffered value load, leading-zero blanking, anti-ghost guard interval.
module hex_scan_driver #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DIV    = 1000,
  parameter int unsigned GUARD  = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
  output logic [3:0]            nibble,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  blank,
  output logic                  pending,
  output logic                  frame
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]         r_pre;
  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_shadow;
  logic [4*DIGITS-1:0]   r_disp;

  logic                  w_tick;
  logic                  w_wrap;
  logic [PW-1:0]         w_pre_n;
  logic [IW-1:0]         w_idx_n;
  logic [4*DIGITS-1:0]   w_shadow_n;
  logic [4*DIGITS-1:0]   w_disp_n;
  logic                  w_pending_n;
  logic                  w_upper_zero;
  logic [3:0]            w_nibble_n;
  logic                  w_blank_n;
  logic [DIGITS-1:0]     w_digit_en_n;

  always_comb begin
    w_tick      = (r_pre == PW'(DIV - 1));
    w_wrap      = w_tick && (r_idx == IW'(DIGITS - 1));
    w_pre_n     = w_tick ? '0 : r_pre + 1'b1;
    w_idx_n     = r_idx;
    if (w_tick) begin
      w_idx_n = w_wrap ? '0 : r_idx + 1'b1;
    end

    // A load landing on the wrap cycle bypasses the shadow straight into disp.
    w_shadow_n  = load ? value : r_shadow;
    w_disp_n    = r_disp;
    w_pending_n = pending;
    if (w_wrap) begin
      w_disp_n    = load ? value : r_shadow;
      w_pending_n = 1'b0;
    end else if (load) begin
      w_pending_n = 1'b1;
    end

    // Outputs are derived from next-state values so the flops carry no lag.
    w_upper_zero = 1'b1;
    w_nibble_n   = 4'h0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (i >= 32'(w_idx_n) && w_disp_n[4*i +: 4] != 4'h0) begin
        w_upper_zero = 1'b0;
      end
      if (i == 32'(w_idx_n)) begin
        w_nibble_n = w_disp_n[4*i +: 4];
      end
    end

    w_blank_n    = (32'(w_pre_n) + 32'd1 <= GUARD) ||
                   (blank_lz && (w_idx_n != '0) && w_upper_zero);
    w_digit_en_n = w_blank_n ? '0 : (DIGITS'(1) << w_idx_n);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pre    <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_disp   <= '0;
      pending  <= 1'b0;
      frame    <= 1'b0;
      nibble   <= '0;
      digit_en <= '0;
      blank    <= 1'b1;
    end else begin
      r_pre    <= w_pre_n;
      r_idx    <= w_idx_n;
      r_shadow <= w_shadow_n;
      r_disp   <= w_disp_n;
      pending  <= w_pending_n;
      frame    <= w_wrap;
      nibble   <= w_nibble_n;
      digit_en <= w_digit_en_n;
      blank    <= w_blank_n;
    end
  end

endmodule
